// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GNT_IF,
    ST_GNT_DM,
    ST_DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_DM
  } gnt_owner_e;

  localparam int STARVE_CNT_W = 4;
  localparam int PERF_CNT_W   = 32;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating wait-cycle counter; only compiled when MEM_ARB_PERF_CNT_EN is defined.
// Counts every cycle inc_i is high, sticks at all-ones, cleared by rst_i.
`ifdef MEM_ARB_PERF_CNT_EN
module mem_arb_perf_cnt
  import mem_arb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inc_i,
  output logic [PERF_CNT_W-1:0] cnt_o
);

  logic [PERF_CNT_W-1:0] cnt_q;
  logic [PERF_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + PERF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one memory port; data wins unless fetch is starved.
// Latency: request to ack = mem latency + 2 cycles; stall_o held while any request lacks its ack.
// Optional wait counters (perf_*_wait_o) exist only with MEM_ARB_PERF_CNT_EN defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_wait_o,
  output logic [31:0]       perf_dm_wait_o
`endif
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  arb_state_e              state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]       dm_rdata_q, dm_rdata_d;
  logic                    if_ack_q, if_ack_d;
  logic                    dm_ack_q, dm_ack_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  gnt_owner_e              winner;
  gnt_owner_e              owner;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    starve_cnt_d = starve_cnt_q;
    winner       = GNT_NONE;
    owner        = GNT_NONE;

    case (state_q)
      ST_IDLE: begin
        if (dm_req_i && !(if_req_i && (starve_cnt_q == STARVE_LIM))) begin
          winner = GNT_DM;
        end else if (if_req_i) begin
          winner = GNT_IF;
        end
        if (!if_req_i) begin
          starve_cnt_d = '0;
        end
        case (winner)
          GNT_DM: begin
            state_d     = ST_GNT_DM;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            if (if_req_i && (starve_cnt_q < STARVE_LIM)) begin
              starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
            end
          end
          GNT_IF: begin
            state_d      = ST_GNT_IF;
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b0;
            mem_addr_d   = if_addr_i;
            mem_wdata_d  = '0;
            starve_cnt_d = '0;
          end
          default: ;
        endcase
      end
      ST_GNT_IF, ST_GNT_DM: begin
        owner = (state_q == ST_GNT_IF) ? GNT_IF : GNT_DM;
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_DONE;
          if (owner == GNT_IF) begin
            if_rdata_d = mem_rdata_i;
            if_ack_d   = 1'b1;
          end else begin
            // stores keep the previous load data visible
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
            dm_ack_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

`ifdef MEM_ARB_PERF_CNT_EN
  mem_arb_perf_cnt u_perf_if (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (if_req_i & ~if_ack_q),
    .cnt_o (perf_if_wait_o)
  );

  mem_arb_perf_cnt u_perf_dm (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (dm_req_i & ~dm_ack_q),
    .cnt_o (perf_dm_wait_o)
  );
`endif

endmodule
